// File: rtl/ts_reader.sv
// Touch-screen reader: requests the shared SPI bus, then runs one X/Y/Z1 burst
// (three back-to-back 24-SCLK frames, mode 0) per accepted sample request.
module ts_reader #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [11:0] Z_THRESH = 12'h100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample,
  output logic        busy,
  output logic        valid,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic [11:0] z1,
  output logic        touched,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        csn
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    CS_SETUP = 3'd2,
    SHIFT    = 3'd3,
    CS_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        half_q, half_d;
  logic [4:0]  bit_q, bit_d;
  logic [1:0]  frame_q, frame_d;
  logic [10:0] sh_q, sh_d;
  logic [11:0] xs_q, xs_d, ys_q, ys_d, zs_q, zs_d;
  logic [11:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic        touched_q, touched_d;

  logic        div_last;
  logic        rise;
  logic        in_frame;
  logic [7:0]  cmd;
  logic [11:0] result;

  assign div_last = (div_q == DIV_LAST);
  // First clk cycle of each SCLK high half is the rising-edge sample point.
  assign rise     = (state_q == SHIFT) && half_q && (div_q == '0);
  assign in_frame = (state_q == CS_SETUP) || (state_q == SHIFT) || (state_q == CS_HOLD);
  assign result   = {sh_q, miso};

  always_comb begin
    cmd = 8'hB0;
    case (frame_q)
      2'd0:    cmd = 8'hD0;
      2'd1:    cmd = 8'h90;
      default: cmd = 8'hB0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    half_d    = half_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    sh_d      = sh_q;
    xs_d      = xs_q;
    ys_d      = ys_q;
    zs_d      = zs_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    touched_d = touched_q;

    case (state_q)
      IDLE: begin
        if (sample) state_d = REQ;
      end
      REQ: begin
        if (bus_gnt) begin
          state_d = CS_SETUP;
          div_d   = '0;
        end
      end
      CS_SETUP: begin
        div_d = div_q + 8'd1;
        if (div_last) begin
          state_d = SHIFT;
          div_d   = '0;
          half_d  = 1'b0;
          bit_d   = '0;
          frame_d = '0;
        end
      end
      SHIFT: begin
        div_d = div_q + 8'd1;
        if (div_last) begin
          div_d  = '0;
          half_d = ~half_q;
          if (half_q) begin
            if (bit_q == 5'd23) begin
              bit_d = '0;
              if (frame_q == 2'd2) begin
                frame_d = '0;
                state_d = CS_HOLD;
              end else begin
                frame_d = frame_q + 2'd1;
              end
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end
        // Rising edges 10..21 carry the result; the 12th bit completes it directly.
        if (rise && (bit_q >= 5'd9) && (bit_q <= 5'd20)) begin
          sh_d = result[10:0];
          if (bit_q == 5'd20) begin
            case (frame_q)
              2'd0:    xs_d = result;
              2'd1:    ys_d = result;
              default: zs_d = result;
            endcase
          end
        end
      end
      CS_HOLD: begin
        div_d = div_q + 8'd1;
        if (div_last) begin
          state_d   = DONE;
          div_d     = '0;
          x_d       = xs_q;
          y_d       = ys_q;
          z_d       = zs_q;
          touched_d = (zs_q >= Z_THRESH);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      half_q    <= 1'b0;
      bit_q     <= '0;
      frame_q   <= '0;
      sh_q      <= '0;
      xs_q      <= '0;
      ys_q      <= '0;
      zs_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      touched_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      sh_q      <= sh_d;
      xs_q      <= xs_d;
      ys_q      <= ys_d;
      zs_q      <= zs_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      touched_q <= touched_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign valid   = (state_q == DONE);
  assign csn     = ~in_frame;
  assign bus_req = (state_q == REQ) || in_frame;
  assign x       = x_q;
  assign y       = y_q;
  assign z1      = z_q;
  assign touched = touched_q;
  // The shared bus lines stay quiet unless the arbiter has granted them.
  assign sclk    = (state_q == SHIFT) && half_q && bus_gnt;
  assign mosi    = (state_q == SHIFT) && (bit_q < 5'd8) && cmd[3'd7 - bit_q[2:0]] && bus_gnt;

endmodule

// File: tb/tb_ts_reader.sv
// Self-checking bench for ts_reader: behavioural touch-controller slave plus
// per-acquisition checks of results, timing, MOSI commands and bus protocol.
module tb_ts_reader;

  localparam int unsigned CD = 4;
  localparam logic [11:0] ZT = 12'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample = 1'b0;
  logic        bus_gnt = 1'b1;
  logic        miso = 1'b0;
  logic        busy, valid, touched, bus_req, sclk, mosi, csn;
  logic [11:0] x, y, z1;

  int errors = 0;
  int checks = 0;

  logic [11:0] resp [3];
  int          edges = 0;
  int          last_edges = 0;
  logic [71:0] mosi_at = '0;
  logic [71:0] mosi_last = '0;

  typedef struct {
    logic [11:0] xv;
    logic [11:0] yv;
    logic [11:0] zv;
    logic        exp_t;
  } vec_t;

  vec_t vecs [6];

  ts_reader #(.CLK_DIV(CD), .Z_THRESH(ZT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sample  (sample),
    .busy    (busy),
    .valid   (valid),
    .x       (x),
    .y       (y),
    .z1      (z1),
    .touched (touched),
    .bus_req (bus_req),
    .bus_gnt (bus_gnt),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .csn     (csn)
  );

  always #5 clk = ~clk;

  // Slave side: count rising SCLK edges per chip-select window and log MOSI.
  always @(posedge sclk or posedge csn) begin
    if (csn === 1'b1) begin
      last_edges = edges;
      mosi_last  = mosi_at;
      mosi_at    = '0;
      edges      = 0;
    end else begin
      if (edges < 72) mosi_at[edges] = mosi;
      edges = edges + 1;
    end
  end

  // Mode-0 slave drives the bit for the next rising edge after each falling edge.
  always @(negedge sclk or negedge csn) begin
    int f, p;
    f = edges / 24;
    p = (edges % 24) + 1;
    if (f < 3 && p >= 10 && p <= 21) miso = resp[f][21 - p];
    else                             miso = 1'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_acq(input logic [11:0] xv, input logic [11:0] yv, input logic [11:0] zv,
                         input logic exp_t, input int gwait, input int dup_at, input string tag);
    int   c, viol, stray;
    bit   got;
    logic p_sclk, p_mosi;
    logic [7:0] b;
    logic [7:0] exp_cmd [3];
    exp_cmd[0] = 8'hD0; exp_cmd[1] = 8'h90; exp_cmd[2] = 8'hB0;
    resp[0] = xv; resp[1] = yv; resp[2] = zv;
    viol = 0; got = 0; p_sclk = 1'b0; p_mosi = 1'b0;
    @(negedge clk);
    sample  = 1'b1;
    bus_gnt = (gwait == 0);
    c = 0;
    while (!got && c < 5000) begin
      @(negedge clk);
      c++;
      sample  = (c == dup_at);
      bus_gnt = (c > gwait);
      #1;
      if (c == 1) check({tag, "_busy_start"}, busy, 1);
      if (sclk && p_sclk && (mosi !== p_mosi)) viol++;
      if (!csn && !(bus_gnt && bus_req)) viol++;
      if (!bus_gnt && (!bus_req || !csn || sclk || mosi)) viol++;
      if (!busy) viol++;
      p_sclk = sclk;
      p_mosi = mosi;
      if (valid === 1'b1) got = 1;
    end
    sample  = 1'b0;
    bus_gnt = 1'b1;
    check({tag, "_valid_seen"}, got, 1);
    check({tag, "_latency"}, c + 1, 2 + (gwait + 1) + CD * (2 + 144));
    check({tag, "_x"}, x, xv);
    check({tag, "_y"}, y, yv);
    check({tag, "_z1"}, z1, zv);
    check({tag, "_touched"}, touched, exp_t);
    check({tag, "_csn_done"}, csn, 1);
    check({tag, "_sclk_edges"}, last_edges, 72);
    stray = 0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) b[7 - k] = mosi_last[24 * f + k];
      check($sformatf("%s_mosi_cmd%0d", tag, f), b, exp_cmd[f]);
      for (int k = 8; k < 24; k++) if (mosi_last[24 * f + k]) stray++;
    end
    check({tag, "_mosi_idle_zero"}, stray, 0);
    check({tag, "_protocol"}, viol, 0);
    @(negedge clk);
    #1;
    check({tag, "_valid_one_cycle"}, valid, 0);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int c, nvalid, nbusy;
    logic [11:0] rx, ry, rz;

    vecs[0] = '{12'hABC, 12'h123, 12'h400, 1'b1};
    vecs[1] = '{12'h5A5, 12'h3C3, 12'h0FF, 1'b0};
    vecs[2] = '{12'h001, 12'h800, 12'h100, 1'b1};
    vecs[3] = '{12'hFFF, 12'h000, 12'hFFF, 1'b1};
    vecs[4] = '{12'h000, 12'hFFF, 12'h000, 1'b0};
    vecs[5] = '{12'h777, 12'h888, 12'h101, 1'b1};

    repeat (3) @(negedge clk);
    #1;
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_z1", z1, 0);
    check("rst_touched", touched, 0);
    check("rst_csn", csn, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_bus_req", bus_req, 0);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("idle_busy", busy, 0);

    for (int i = 0; i < 6; i++)
      run_acq(vecs[i].xv, vecs[i].yv, vecs[i].zv, vecs[i].exp_t, 0, 0, $sformatf("vec%0d", i));

    run_acq(12'h246, 12'h9BD, 12'h0FF, 1'b0, 50, 0, "gnt_wait");

    run_acq(12'h321, 12'h654, 12'h987, 1'b1, 0, 200, "dup");
    nvalid = 0; nbusy = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      #1;
      if (valid) nvalid++;
      if (busy) nbusy++;
    end
    check("dup_no_extra_valid", nvalid, 0);
    check("dup_no_extra_busy", nbusy, 0);
    run_acq(12'h135, 12'h7E1, 12'h200, 1'b1, 0, 0, "after_dup");

    for (int i = 0; i < 6; i++) begin
      rx = 12'($urandom);
      ry = 12'($urandom);
      rz = (i < 3) ? 12'(ZT + $urandom_range(0, 2) - 1) : 12'($urandom);
      run_acq(rx, ry, rz, (rz >= ZT), $urandom_range(0, 4), 0, $sformatf("rand%0d", i));
    end

    resp[0] = 12'hAAA; resp[1] = 12'h555; resp[2] = 12'hFFF;
    @(negedge clk);
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    c = 0;
    while (edges < 30 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("rst_mid_reached_y", (edges >= 30), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_csn", csn, 1);
    check("rst_mid_x", x, 0);
    check("rst_mid_y", y, 0);
    check("rst_mid_z1", z1, 0);
    check("rst_mid_touched", touched, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", valid, 0);
    check("rst_mid_bus_req", bus_req, 0);
    check("rst_mid_sclk", sclk, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (busy || !csn || valid) nbusy++;
    end
    check("rst_mid_stays_idle", nbusy, 0);
    run_acq(12'hABC, 12'h123, 12'h400, 1'b1, 0, 0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ts_reader.md
TS_READER -- requirements
Module: ts_reader

Interface
REQ-001 Parameter CLK_DIV, default 4, means clk cycles per SCLK half-period (legal 2..255).
REQ-002 Parameter Z_THRESH, default 12'h100, means the minimum Z1 value that counts as a touch.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-005 sample  input  1  one-cycle request to run one X/Y/Z1 acquisition.
REQ-006 busy  output  1  high from accepted sample until valid pulse inclusive.
REQ-007 valid  output  1  one-cycle strobe; x, y, z1 and touched are updated this cycle.
REQ-008 x, y, z1  output  12 each  last captured conversion results.
REQ-009 touched  output  1  z1 >= Z_THRESH for the last completed acquisition.
REQ-010 bus_req  output  1  request for the shared SPI bus (SCLK/MOSI) owned jointly with the TFT controller.
REQ-011 bus_gnt  input  1  SPI bus granted; the block drives sclk/mosi only while granted.
REQ-012 sclk, mosi  output  1 each  SPI mode 0 to the touch controller.
REQ-013 miso  input  1  serial data from the touch controller.
REQ-014 csn  output  1  touch controller chip select, active low.

Function
REQ-015 The FSM states SHALL be IDLE, REQ, CS_SETUP, SHIFT, CS_HOLD, DONE.
REQ-016 IDLE: sample=1 -> REQ and busy=1 the next cycle; sample while busy is ignored (not queued).
REQ-017 REQ: bus_req=1; on bus_gnt=1 -> CS_SETUP; bus_req stays 1 through CS_HOLD.
REQ-018 CS_SETUP: csn=0, sclk=0 for CLK_DIV cycles, then SHIFT.
REQ-019 SHIFT runs three back-to-back 24-SCLK frames with csn held low: X (cmd 8'hD0), Y (8'h90), Z1 (8'hB0).
REQ-020 SCLK timing: low half then high half, each CLK_DIV clk cycles; the first rising edge occurs CLK_DIV cycles after SHIFT entry.
REQ-021 MOSI: command bits MSB first, valid before rising edges 1..8 of each frame, changing only while sclk=0; mosi=0 at all other times.
REQ-022 MISO sampling: on the clk cycle of each rising sclk edge; rising edges 10..21 of a frame form the 12-bit result MSB first; all other edges are ignored.
REQ-023 After the 72nd SCLK high half, sclk returns low -> CS_HOLD: csn=0, sclk=0 for CLK_DIV cycles, then csn=1 and bus_req=0 -> DONE.
REQ-024 DONE (one cycle): x, y, z1 update simultaneously, touched = (z1_new >= Z_THRESH) unsigned, valid=1, busy=1; next cycle IDLE with busy=0.
REQ-025 Outputs x/y/z1/touched SHALL hold their values between valid strobes; partial results never appear on outputs.
REQ-026 While bus_gnt=0 the block SHALL not toggle sclk or mosi; the bus arbiter holds the grant until bus_req falls, and gnt loss mid-frame is out of contract.
REQ-027 Bit/edge counters SHALL wrap cleanly: the frame counter runs 0..2 and the bit counter 0..23, with no 4th frame.
REQ-028 Latency from sample to valid SHALL be exactly 1 + G + CLK_DIV*(2 + 144) + 1 cycles, where G = cycles spent in REQ (G >= 1).

Reset
REQ-029 rst_n=0 asynchronously SHALL force state IDLE, csn=1, sclk=0, mosi=0, bus_req=0, busy=0, valid=0, x=y=z1=0, touched=0, and clear all counters.
REQ-030 Reset mid-acquisition SHALL discard partial data; after release, the block idles until a new sample.

Verification
REQ-031 MISO model returns X=12'hABC, Y=12'h123, Z1=12'h400, CLK_DIV=4, gnt tied 1 -> valid once; x=ABC, y=123, z1=400, touched=1; 72 sclk rising edges; MOSI bytes D0, 90, B0.
REQ-032 Z1=12'h0FF, then 12'h100 on a second run -> touched=0, then 1.
REQ-033 bus_gnt held 0 for 50 cycles after sample -> bus_req=1, csn=1, sclk static; after grant, the normal frame and latency = REQ-028 with G=51.
REQ-034 Second sample pulse issued mid-SHIFT -> ignored; exactly one valid strobe; the next sample after busy=0 starts a new acquisition.
REQ-035 rst_n pulsed low during the Y frame -> outputs immediately at reset values, csn=1 within the same cycle; the subsequent sample completes normally.
REQ-036 Checker: mosi never changes while sclk=1; csn low only between bus_gnt and bus_req fall.
